// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared widths, scan-state encoding and leading-zero helper for
//            the seven-segment scan path.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;
    localparam int VALUE_W    = DIGIT_W * NUM_DIGITS;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // True when digit sel and every more-significant digit of value are zero.
    // Digit 0 always returns false so a zero value still lights one digit.
    function automatic logic lz_blank(input logic [VALUE_W-1:0] value,
                                      input logic [SEL_W-1:0]   sel);
        logic blank;
        case (sel)
            2'd1:    blank = (value[VALUE_W-1:DIGIT_W]   == '0);
            2'd2:    blank = (value[VALUE_W-1:2*DIGIT_W] == '0);
            2'd3:    blank = (value[VALUE_W-1:3*DIGIT_W] == '0);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : scan_prescaler
// Brief    : Free-running 0..DIV-1 counter with a wrap flag on the last count.
// Revision : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
    parameter int DIV   = 100000,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [CNT_W-1:0] o_tick_cnt,
    output logic             o_slot_wrap
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_tick_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == C_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    assign o_tick_cnt  = r_tick_cnt;
    assign o_slot_wrap = (r_tick_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Four-digit scan controller with frame-aligned source snapshot,
//            per-slot anti-ghost blanking and leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [VALUE_W-1:0]  value_a,
    input  logic [VALUE_W-1:0]  value_b,
    input  logic                req_b,
    input  logic                freeze,
    input  logic                lz_suppress,
    output logic [DIGIT_W-1:0]  digit_in,
    output logic [SEL_W-1:0]    digit_select,
    output logic                digit_en,
    output logic                src_sel,
    output logic                frame_done
);

    localparam int                 C_CNT_W   = $clog2(SCAN_DIV);
    localparam int                 C_IDX_W   = $clog2(VALUE_W);
    localparam logic [C_CNT_W-1:0] C_BLANK   = C_CNT_W'(BLANK_CYC);
    localparam logic [C_CNT_W-1:0] C_LAST    = C_CNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]   C_LAST_DG = SEL_W'(NUM_DIGITS - 1);

    logic [C_CNT_W-1:0] w_tick_cnt;
    logic [C_CNT_W-1:0] w_next_tick;
    logic               w_slot_wrap;
    logic [SEL_W-1:0]   w_next_sel;
    logic [C_IDX_W-1:0] w_digit_lsb;
    logic [VALUE_W-1:0] w_snap;
    logic [VALUE_W-1:0] w_shadow_nxt;
    logic               w_load;
    logic               w_supp_next;

    logic [SEL_W-1:0]   r_digit_select;
    logic [DIGIT_W-1:0] r_digit_in;
    logic               r_digit_en;
    logic               r_src_sel;
    logic               r_frame_done;
    logic [VALUE_W-1:0] r_shadow;
    logic               r_frame_start;
    scan_state_t        r_state;

    scan_prescaler #(
        .DIV   (SCAN_DIV),
        .CNT_W (C_CNT_W)
    ) u_prescaler (
        .clk         (clk),
        .reset_n     (reset_n),
        .o_tick_cnt  (w_tick_cnt),
        .o_slot_wrap (w_slot_wrap)
    );

    // Every registered output is computed from the slot position it will
    // hold after the edge, so the nibble is already stable while blanked.
    always_comb begin
        w_next_tick  = w_slot_wrap ? '0 : w_tick_cnt + C_CNT_W'(1);
        w_next_sel   = w_slot_wrap ? r_digit_select + SEL_W'(1) : r_digit_select;
        w_digit_lsb  = {w_next_sel, 2'b00};
        w_snap       = req_b ? value_b : value_a;
        w_load       = r_frame_start && !freeze;
        w_shadow_nxt = w_load ? w_snap : r_shadow;
        w_supp_next  = lz_suppress && lz_blank(w_shadow_nxt, w_next_sel);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit_select <= '0;
            r_digit_in     <= '0;
            r_src_sel      <= 1'b0;
            r_frame_done   <= 1'b0;
            r_shadow       <= '0;
            r_frame_start  <= 1'b1;
        end else begin
            r_digit_select <= w_next_sel;
            r_digit_in     <= w_shadow_nxt[w_digit_lsb +: DIGIT_W];
            r_frame_start  <= w_slot_wrap && (r_digit_select == C_LAST_DG);
            r_frame_done   <= (w_next_tick == C_LAST) && (w_next_sel == C_LAST_DG);
            if (w_load) begin
                r_shadow  <= w_snap;
                r_src_sel <= req_b;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= BLANK;
            r_digit_en <= 1'b0;
        end else begin
            case (r_state)
                BLANK: begin
                    if (w_next_tick == C_BLANK) begin
                        r_state    <= SHOW;
                        r_digit_en <= !w_supp_next;
                    end else begin
                        r_digit_en <= 1'b0;
                    end
                end
                SHOW: begin
                    if (w_slot_wrap) begin
                        r_state    <= BLANK;
                        r_digit_en <= 1'b0;
                    end else begin
                        r_digit_en <= !w_supp_next;
                    end
                end
                default: begin
                    r_state    <= BLANK;
                    r_digit_en <= 1'b0;
                end
            endcase
        end
    end

    assign digit_in     = r_digit_in;
    assign digit_select = r_digit_select;
    assign digit_en     = r_digit_en;
    assign src_sel      = r_src_sel;
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Frame-level vector table plus reset sequences for seg_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] value_a;
    logic [15:0] value_b;
    logic        req_b;
    logic        freeze;
    logic        lz_suppress;
    logic [3:0]  digit_in;
    logic [1:0]  digit_select;
    logic        digit_en;
    logic        src_sel;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         pos;
        logic [1:0] sel;
        logic [3:0] din;
        logic       din_chk;
        logic       en;
        logic       src;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        rq;
        logic        fz;
        logic        lz;
        logic [15:0] want_val;
        logic        want_src;
        logic [3:0]  mask;
    } row_t;

    exp_t q[$];
    row_t rows[8];

    seg_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .value_a      (value_a),
        .value_b      (value_b),
        .req_b        (req_b),
        .freeze       (freeze),
        .lz_suppress  (lz_suppress),
        .digit_in     (digit_in),
        .digit_select (digit_select),
        .digit_en     (digit_en),
        .src_sel      (src_sel),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int pos, input logic [15:0] act,
                       input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s pos=%0d got=%0h want=%0h", nm, pos, act, want);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_digit_in"},     -1, 16'(digit_in),     16'h0);
        chk({tag, "_digit_select"}, -1, 16'(digit_select), 16'h0);
        chk({tag, "_digit_en"},     -1, 16'(digit_en),     16'h0);
        chk({tag, "_src_sel"},      -1, 16'(src_sel),      16'h0);
        chk({tag, "_frame_done"},   -1, 16'(frame_done),   16'h0);
    endtask

    // Scoreboard consumer: outputs settle shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("digit_select", e.pos, 16'(digit_select), 16'(e.sel));
                chk("digit_en",     e.pos, 16'(digit_en),     16'(e.en));
                chk("src_sel",      e.pos, 16'(src_sel),      16'(e.src));
                chk("frame_done",   e.pos, 16'(frame_done),   16'(e.fd));
                if (e.din_chk)
                    chk("digit_in", e.pos, 16'(digit_in), 16'(e.din));
            end
        end
    end

    // Entered at the falling edge of frame position 0. Inputs are applied
    // there so the coming edge takes the snapshot; each iteration queues the
    // outputs expected at the next frame position.
    task automatic run_frame(input logic [15:0] va, input logic [15:0] vb,
                             input logic rq, input logic fz, input logic lz,
                             input logic [15:0] want_val, input logic want_src,
                             input logic [3:0] mask, input int chg_p,
                             input logic [15:0] chg_va, input logic [15:0] chg_vb,
                             input logic chg_rq, input int ncyc);
        exp_t e;
        int   qp;
        int   tick;
        int   sel;
        value_a     = va;
        value_b     = vb;
        req_b       = rq;
        freeze      = fz;
        lz_suppress = lz;
        for (int p = 0; p < ncyc; p++) begin
            if (p == chg_p) begin
                value_a = chg_va;
                value_b = chg_vb;
                req_b   = chg_rq;
            end
            qp        = (p + 1) % FRAME;
            tick      = qp % SCAN_DIV;
            sel       = qp / SCAN_DIV;
            e.pos     = qp;
            e.sel     = 2'(sel);
            e.din     = want_val[sel*4 +: 4];
            e.din_chk = (qp != 0);
            e.en      = (tick >= BLANK_CYC) && mask[sel];
            e.src     = want_src;
            e.fd      = (qp == FRAME - 1);
            q.push_back(e);
            @(negedge clk);
        end
    endtask

    initial begin
        rows[0] = '{16'h5678, 16'h0042, 1'b1, 1'b0, 1'b1, 16'h0042, 1'b1, 4'b0011};
        rows[1] = '{16'h0000, 16'h0042, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 4'b0001};
        rows[2] = '{16'h0100, 16'h0042, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 4'b0111};
        rows[3] = '{16'hABCD, 16'h0042, 1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 4'b0111};
        rows[4] = '{16'hABCD, 16'h0042, 1'b1, 1'b1, 1'b0, 16'h0100, 1'b0, 4'b1111};
        rows[5] = '{16'hABCD, 16'h0042, 1'b0, 1'b0, 1'b0, 16'hABCD, 1'b0, 4'b1111};
        rows[6] = '{16'h9000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h9000, 1'b0, 4'b1111};
        rows[7] = '{16'h1234, 16'hF10F, 1'b1, 1'b0, 1'b1, 16'hF10F, 1'b1, 4'b1111};

        reset_n     = 1'b0;
        value_a     = 16'h1234;
        value_b     = 16'h0000;
        req_b       = 1'b0;
        freeze      = 1'b0;
        lz_suppress = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        reset_n = 1'b1;
        check_reset("release");

        run_frame(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 4'b1111,
                  -1, 16'h0, 16'h0, 1'b0, FRAME);
        // value_a changes inside the digit 1 slot; this frame keeps 1234
        run_frame(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 4'b1111,
                  10, 16'h5678, 16'h0000, 1'b0, FRAME);
        // req_b rises inside the digit 2 slot; source switches next frame
        run_frame(16'h5678, 16'h0042, 1'b0, 1'b0, 1'b0, 16'h5678, 1'b0, 4'b1111,
                  18, 16'h5678, 16'h0042, 1'b1, FRAME);
        run_frame(16'h5678, 16'h0042, 1'b1, 1'b0, 1'b0, 16'h0042, 1'b1, 4'b1111,
                  -1, 16'h0, 16'h0, 1'b0, FRAME);

        for (int i = 0; i < 8; i++) begin
            run_frame(rows[i].va, rows[i].vb, rows[i].rq, rows[i].fz, rows[i].lz,
                      rows[i].want_val, rows[i].want_src, rows[i].mask,
                      -1, 16'h0, 16'h0, 1'b0, FRAME);
        end

        // Stop in the SHOW phase of the digit 2 slot, then reset there.
        run_frame(16'h1234, 16'hF10F, 1'b1, 1'b0, 1'b0, 16'hF10F, 1'b1, 4'b1111,
                  -1, 16'h0, 16'h0, 1'b0, 20);
        chk("pre_rst_digit_en",     20, 16'(digit_en),     16'h1);
        chk("pre_rst_digit_select", 20, 16'(digit_select), 16'h2);
        chk("pre_rst_digit_in",     20, 16'(digit_in),     16'h1);
        chk("pre_rst_src_sel",      20, 16'(src_sel),      16'h1);
        value_a     = 16'h0305;
        req_b       = 1'b0;
        lz_suppress = 1'b1;
        reset_n     = 1'b0;
        #1;
        check_reset("async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_reset("restart");
        run_frame(16'h0305, 16'hF10F, 1'b0, 1'b0, 1'b1, 16'h0305, 1'b0, 4'b0111,
                  -1, 16'h0, 16'h0, 1'b0, FRAME);
        run_frame(16'h0305, 16'hF10F, 1'b0, 1'b0, 1'b1, 16'h0305, 1'b0, 4'b0111,
                  -1, 16'h0, 16'h0, 1'b0, FRAME);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Display scan controller that time-multiplexes a 16-bit, 4-nibble value onto the four-digit seven-segment decoder.
- Arbitrates between two value sources (up-counter, stopwatch) at frame boundaries only, snapshotting the chosen value to prevent tearing.
- Inserts an anti-ghosting blank interval at the start of every digit slot and suppresses leading zeros.
- Sits between the counter/stopwatch datapaths and SevenSegment; replaces ad-hoc per-clock digit rotation.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range 2..2^20.
- BLANK_CYC, 1000, cycles at slot start with the digit disabled; legal range 1..SCAN_DIV-1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- value_a  in  16  source A (counter), nibble k = digit k, digit 0 = least significant
- value_b  in  16  source B (stopwatch), same packing
- req_b  in  1  source B requests the display (level)
- freeze  in  1  hold current snapshot and source
- lz_suppress  in  1  enable leading-zero blanking
- digit_in  out  4  nibble for the decoder
- digit_select  out  2  active digit index
- digit_en  out  1  anode enable; 0 = all anodes off
- src_sel  out  1  source currently shown (0 = A, 1 = B)
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async assert, sync-released sampling) forces: tick_cnt=0, digit_select=0, digit_in=0, digit_en=0, src_sel=0, frame_done=0, shadow=0, frame_start flag=1.
- All outputs are registered.
- Slot timing:
  - tick_cnt counts 0..SCAN_DIV-1, then wraps.
  - digit_select increments (3 wraps to 0) on the cycle tick_cnt wraps.
  - Each slot is exactly SCAN_DIV cycles. A full frame is 4*SCAN_DIV cycles.
- State machine per slot:
  - BLANK: tick_cnt < BLANK_CYC. digit_en=0.
  - SHOW: tick_cnt >= BLANK_CYC. digit_en=1 unless suppressed.
  - BLANK→SHOW when tick_cnt reaches BLANK_CYC. SHOW→BLANK on slot wrap.
- Frame boundary: the first cycle of the digit 0 slot, including the first clock edge after reset release. At the boundary:
  - freeze=0: src_sel <= req_b; shadow <= req_b ? value_b : value_a.
  - freeze=1: shadow and src_sel are unchanged.
- Arbitration:
  - Source changes only at frame boundaries. req_b toggling mid-frame has no effect until the next boundary.
  - No starvation logic. B has priority while requesting.
- digit_in = shadow[4*digit_select +: 4], valid from the first BLANK cycle of the slot, so the decoder settles during blanking.
- Leading-zero suppression (lz_suppress=1):
  - Digit k in {1,2,3} is suppressed if shadow nibbles k..3 are all zero.
  - Suppressed digit: digit_en stays 0 for the whole slot.
  - Digit 0 is never suppressed.
  - lz_suppress is sampled every cycle (combinational into the digit_en register).
- frame_done: pulses high for 1 cycle coinciding with the last cycle of the digit 3 slot (tick_cnt = SCAN_DIV-1, digit_select = 3).
- Reset mid-frame aborts the frame immediately: outputs go to reset values, and the frame restarts at digit 0 with a fresh snapshot.
- Values change mid-frame: the display is unaffected (shadowed).
- Widths: tick_cnt is $clog2(SCAN_DIV) bits. No arithmetic is performed on the value path.

Decomposition:
- Shared package seg_pkg: DIGIT_W=4, NUM_DIGITS=4, SEL_W=2, scan state enum {BLANK, SHOW}.
- One sub-module, scan_prescaler: parameter DIV; outputs a tick_cnt value and a slot_wrap pulse. Reusable by the clock divider.
- Arbitration, snapshot and suppression stay in seg_scan_ctrl.

Test Plan (SCAN_DIV=8, BLANK_CYC=2):
- Reset, value_a=16'h1234, req_b=0, lz_suppress=0 → digit_select cycles 0,1,2,3 every 8 cycles; digit_in 4,3,2,1; digit_en low 2 cycles then high 6 per slot; frame_done pulses every 32 cycles; src_sel=0.
- Mid-frame (digit 1 slot) change value_a 1234→5678 → remainder of frame still shows 2,1 on digits 2,3; next frame shows 8,7,6,5.
- Raise req_b during digit 2 slot with value_b=16'h0042 → src_sel stays 0 until the next digit 0 slot start, then becomes 1; digits read 2,4,0,0.
- lz_suppress=1, shown value 16'h0042 → digit_en never asserts in slots 2,3; slots 0,1 enable normally. Value 16'h0000 → only digit 0 enabled.
- freeze=1 across a boundary while value_a changes and req_b toggles → shadow and src_sel unchanged. After freeze=0, the next boundary updates both.
- Assert reset_n=0 in the middle of the digit 2 SHOW phase → all outputs reach reset values asynchronously. After release, the first slot is digit 0 BLANK with a new snapshot.
